// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiplier: operation modes, FSM states
// and the radix legality rule.
package mul_pkg;

    localparam logic [1:0] MODE_MUL   = 2'b00;
    localparam logic [1:0] MODE_MLA   = 2'b01;
    localparam logic [1:0] MODE_UMULL = 2'b10;
    localparam logic [1:0] MODE_SMULL = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;

    function automatic bit step_legal(input int step, input int width);
        return ((step == 1) || (step == 2) || (step == 4)) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^STEP iteration: adds mcand * mbits into the running accumulator.
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [STEP-1:0]    i_mbits,
    input  logic [2*WIDTH-1:0] i_acc,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] w_sum;

    // Shift-and-add over the multiplier bits retired this cycle.
    always_comb begin
        w_sum = i_acc;
        for (int i = 0; i < STEP; i++) begin
            if (i_mbits[i]) begin
                w_sum = w_sum + (i_mcand << i);
            end else begin
                w_sum = w_sum;
            end
        end
    end

    assign o_acc = w_sum;

endmodule

// File: rtl/iter_multiplier.sv
// Iterative MUL/MLA/UMULL/SMULL unit: IDLE -> RUN (WIDTH/STEP cycles) -> FINISH,
// with sign and accumulate correction applied in FINISH and all outputs registered.
module iter_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flags
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]      CNT_INIT = CW'(N);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2 * WIDTH)'(1);

    if (!step_legal(STEP, WIDTH)) begin : g_step_check
        $error("iter_multiplier: STEP must be 1, 2 or 4 and divide WIDTH");
    end

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_mode;
    logic               r_sign;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_acc;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [1:0]         r_flags;

    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic               w_sign;
    logic [2*WIDTH-1:0] w_step_sum;
    logic [2*WIDTH-1:0] w_full;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;
    logic [1:0]         w_flags;

    // SMULL runs on magnitudes; the most negative value negates onto itself,
    // which is exactly its unsigned magnitude.
    always_comb begin
        w_opa  = a;
        w_opb  = b;
        w_sign = 1'b0;
        if (mode == MODE_SMULL) begin
            w_opa  = a[WIDTH-1] ? (~a + ONE_W) : a;
            w_opb  = b[WIDTH-1] ? (~b + ONE_W) : b;
            w_sign = a[WIDTH-1] ^ b[WIDTH-1];
        end else begin
            w_opa  = a;
            w_opb  = b;
            w_sign = 1'b0;
        end
    end

    mul_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_mcand (r_mcand),
        .i_mbits (r_mplier[STEP-1:0]),
        .i_acc   (r_prod),
        .o_acc   (w_step_sum)
    );

    // Per-mode correction of the raw magnitude product and flag derivation.
    always_comb begin
        w_full  = r_sign ? (~r_prod + ONE_2W) : r_prod;
        w_lo    = w_full[WIDTH-1:0];
        w_hi    = {WIDTH{1'b0}};
        w_flags = 2'b00;
        case (r_mode)
            MODE_MUL: begin
                w_lo    = w_full[WIDTH-1:0];
                w_hi    = {WIDTH{1'b0}};
                w_flags = {w_lo[WIDTH-1], (w_lo == {WIDTH{1'b0}})};
            end
            MODE_MLA: begin
                w_lo    = w_full[WIDTH-1:0] + r_acc;
                w_hi    = {WIDTH{1'b0}};
                w_flags = {w_lo[WIDTH-1], (w_lo == {WIDTH{1'b0}})};
            end
            MODE_UMULL, MODE_SMULL: begin
                w_lo    = w_full[WIDTH-1:0];
                w_hi    = w_full[2*WIDTH-1:WIDTH];
                w_flags = {w_hi[WIDTH-1], (w_full == {(2 * WIDTH){1'b0}})};
            end
            default: begin
                w_lo    = {WIDTH{1'b0}};
                w_hi    = {WIDTH{1'b0}};
                w_flags = 2'b00;
            end
        endcase
    end

    // FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= {CW{1'b0}};
            r_mode   <= 2'b00;
            r_sign   <= 1'b0;
            r_mcand  <= {(2 * WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_prod   <= {(2 * WIDTH){1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_lo     <= {WIDTH{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_flags  <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_sign   <= w_sign;
                        r_mcand  <= {{WIDTH{1'b0}}, w_opa};
                        r_mplier <= w_opb;
                        r_acc    <= (mode == MODE_MLA) ? acc : {WIDTH{1'b0}};
                        r_prod   <= {(2 * WIDTH){1'b0}};
                        r_count  <= CNT_INIT;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_prod   <= w_step_sum;
                    r_mplier <= r_mplier >> STEP;
                    r_mcand  <= r_mcand << STEP;
                    r_count  <= r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FINISH: begin
                    r_lo    <= w_lo;
                    r_hi    <= w_hi;
                    r_flags <= w_flags;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign flags     = r_flags;

endmodule

// File: tb/tb_iter_multiplier.sv
// Bench for iter_multiplier: STEP=1 and STEP=4 instances share stimulus and are
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_iter_multiplier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] acc = 32'd0;

    logic        busy_o [2];
    logic        done_o [2];
    logic [31:0] lo_o   [2];
    logic [31:0] hi_o   [2];
    logic [1:0]  fl_o   [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int          nn    [2] = '{32, 8};
    int          ph    [2] = '{0, 0};
    logic [65:0] pend  [2];
    logic [31:0] e_lo  [2] = '{32'd0, 32'd0};
    logic [31:0] e_hi  [2] = '{32'd0, 32'd0};
    logic [1:0]  e_fl  [2] = '{2'b00, 2'b00};

    always #5 clk = ~clk;

    iter_multiplier #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b), .acc(acc),
        .busy(busy_o[0]), .done(done_o[0]), .result_lo(lo_o[0]), .result_hi(hi_o[0]), .flags(fl_o[0])
    );

    iter_multiplier #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b), .acc(acc),
        .busy(busy_o[1]), .done(done_o[1]), .result_lo(lo_o[1]), .result_hi(hi_o[1]), .flags(fl_o[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo, N, Z} straight from the arithmetic definition.
    function automatic logic [65:0] model(input logic [1:0] m, input logic [31:0] x, y, z);
        logic [63:0] full;
        logic [31:0] lo, hi;
        longint      sp;
        logic [1:0]  fl;
        if (m == 2'b11) begin
            sp   = longint'(signed'(x)) * longint'(signed'(y));
            full = 64'(sp);
        end else begin
            full = {32'd0, x} * {32'd0, y};
        end
        case (m)
            2'b00:   begin lo = full[31:0];       hi = 32'd0; end
            2'b01:   begin lo = full[31:0] + z;   hi = 32'd0; end
            default: begin lo = full[31:0];       hi = full[63:32]; end
        endcase
        if (m[1]) fl = {hi[31], ({hi, lo} == 64'd0)};
        else      fl = {lo[31], (lo == 32'd0)};
        return {hi, lo, fl};
    endfunction

    // Reference timing: ph counts cycles since the accepted start.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                ph[d] = 0; e_lo[d] = 32'd0; e_hi[d] = 32'd0; e_fl[d] = 2'b00;
            end else if (ph[d] == 0 || ph[d] == nn[d] + 2) begin
                if (start) begin
                    ph[d] = 1;
                    pend[d] = model(mode, a, b, acc);
                end else begin
                    ph[d] = 0;
                end
            end else begin
                ph[d] = ph[d] + 1;
                if (ph[d] == nn[d] + 2) {e_hi[d], e_lo[d], e_fl[d]} = pend[d];
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy%0d", d), 64'(busy_o[d]), 64'(ph[d] >= 1 && ph[d] <= nn[d] + 1));
                chk($sformatf("done%0d", d), 64'(done_o[d]), 64'(ph[d] == nn[d] + 2));
                chk($sformatf("lo%0d", d), 64'(lo_o[d]), 64'(e_lo[d]));
                chk($sformatf("hi%0d", d), 64'(hi_o[d]), 64'(e_hi[d]));
                chk($sformatf("flags%0d", d), 64'(fl_o[d]), 64'(e_fl[d]));
            end
        end
    end

    task automatic step_cyc();
        @(posedge clk); #1;
    endtask

    // Issue one op from an idle state, check done cycle and literal results on both.
    task automatic op(input string nm, input logic [1:0] m, input logic [31:0] x, y, z,
                      input logic [31:0] elo, ehi, input logic [1:0] efl);
        int c0 = -1;
        int c1 = -1;
        start = 1'b1; mode = m; a = x; b = y; acc = z;
        step_cyc();
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (done_o[0] && c0 < 0) begin
                c0 = k;
                chk({nm, "_lo"}, 64'(lo_o[0]), 64'(elo));
                chk({nm, "_hi"}, 64'(hi_o[0]), 64'(ehi));
                chk({nm, "_fl"}, 64'(fl_o[0]), 64'(efl));
            end
            if (done_o[1] && c1 < 0) begin
                c1 = k;
                chk({nm, "_lo4"}, 64'(lo_o[1]), 64'(elo));
                chk({nm, "_fl4"}, 64'(fl_o[1]), 64'(efl));
            end
            if (c0 >= 0 && c1 >= 0) break;
            step_cyc();
        end
        chk({nm, "_lat1"}, 64'(c0), 64'd34);
        chk({nm, "_lat4"}, 64'(c1), 64'd10);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ndone;
        logic [65:0] mr;
        step_cyc();
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy_o[0]), 64'd0);
        chk("rst_lo", 64'(lo_o[0]), 64'd0);
        reset = 1'b0;

        // Pin the reference model with hand-computed values.
        mr = model(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        chk("mdl_umull", 64'(mr), 64'({32'hFFFF_FFFE, 32'h0000_0001, 2'b10}));
        mr = model(2'b11, 32'hFFFF_FFFE, 32'd3, 32'd0);
        chk("mdl_smull", 64'(mr), 64'({32'hFFFF_FFFF, 32'hFFFF_FFFA, 2'b10}));
        mr = model(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd5);
        chk("mdl_mla", 64'(mr), 64'({32'd0, 32'd5, 2'b00}));

        step_cyc();
        op("mul", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 32'd0, 2'b00);
        op("umull", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, 2'b10);
        op("smull_neg", 2'b11, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 2'b10);
        op("smull_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'h4000_0000, 2'b00);
        op("smull_zero", 2'b11, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 2'b01);
        op("mla", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd5, 32'd5, 32'd0, 2'b00);

        // Start pulsed in cycle 5 of a busy MUL must be ignored.
        start = 1'b1; mode = 2'b00; a = 32'd3; b = 32'd5;
        for (int k = 1; k <= 40; k++) begin
            step_cyc();
            start = (k == 5);
            if (k == 5) begin mode = 2'b10; a = 32'd9; b = 32'd9; end
            if (done_o[0]) begin
                chk("ignore_lo", 64'(lo_o[0]), 64'd15);
                chk("ignore_cyc", 64'(k), 64'd34);
                break;
            end
        end
        start = 1'b0;
        step_cyc();

        // Reset in cycle 12 aborts the run with no done.
        start = 1'b1; mode = 2'b10; a = 32'h1234_5678; b = 32'd99;
        step_cyc();
        start = 1'b0;
        repeat (11) step_cyc();
        reset = 1'b1;
        step_cyc();
        reset = 1'b0;
        chk("abort_busy", 64'(busy_o[0]), 64'd0);
        chk("abort_lo", 64'(lo_o[0]), 64'd0);
        chk("abort_hi4", 64'(hi_o[1]), 64'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_o[0]) ndone++;
            step_cyc();
        end
        chk("abort_nodone", 64'(ndone), 64'd0);

        // Reset and start together: stays idle.
        reset = 1'b1; start = 1'b1;
        step_cyc();
        reset = 1'b0; start = 1'b0;
        step_cyc();
        chk("rst_start_idle", 64'(busy_o[0]), 64'd0);

        // Randomized traffic, including starts while busy and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            mode  = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            acc   = pick();
            step_cyc();
        end
        reset = 1'b0; start = 1'b0;
        repeat (40) step_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_multiplier.md
# iter_multiplier

Parametrised iterative multiply unit for the multi-cycle ARM datapath; successor to the single-cycle ALU multiply path. Supports MUL, MLA, UMULL and SMULL at configurable operand width and radix (bits retired per cycle). Sits beside the ALU; the control FSM holds in a wait state on `busy` and writes back on `done`.

## Interface

- `WIDTH`, 32: operand width; result is 2*WIDTH.
- `STEP`, 1: multiplier bits retired per cycle; legal values 1, 2, 4; must divide WIDTH.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; accepted only in IDLE.
- `mode` in 2: 00 MUL, 01 MLA, 10 UMULL, 11 SMULL; sampled with `start`.
- `a` in WIDTH: multiplicand (Rm); sampled with `start`.
- `b` in WIDTH: multiplier (Rs); sampled with `start`.
- `acc` in WIDTH: MLA addend (Ra); sampled with `start`, ignored in other modes.
- `busy` out 1: high in RUN and FINISH.
- `done` out 1: one-cycle pulse; results are valid from this cycle.
- `result_lo` out WIDTH: low half (MUL/MLA destination, RdLo for long).
- `result_hi` out WIDTH: high half (RdHi); 0 for MUL/MLA.
- `flags` out 2: {N, Z} of the written result.

## Operation

- States: IDLE, RUN, FINISH.
- IDLE, `start`=1: capture mode and operands. Set count = WIDTH/STEP, clear the 2*WIDTH accumulator, go to RUN.
  - SMULL: store |a| and |b|, and sign = a[msb]^b[msb].
  - Other modes: operands are used unsigned.
- RUN: each cycle add (mcand × low STEP bits of multiplier) into the accumulator, shift the multiplier right by STEP, shift mcand left by STEP, decrement count. Go to FINISH when count reaches 1 this cycle, so exactly WIDTH/STEP RUN cycles.
- FINISH: apply per-mode correction and register outputs, pulse `done`, go to IDLE.
  - SMULL: two's-complement negate the 2*WIDTH product if sign=1.
  - MLA: lo = (product[WIDTH-1:0] + acc) mod 2^WIDTH.
  - MUL/MLA: hi = 0.
- Arithmetic rules:
  - Magnitude of the most negative value is 2^(WIDTH-1) and fits unsigned.
  - Full product never overflows 2*WIDTH.
  - MLA carry out is discarded.
- Flags:
  - MUL/MLA: N = lo[msb], Z = (lo==0).
  - UMULL/SMULL: N = hi[msb], Z = ({hi,lo}==0).
  - C and V are not produced; the caller preserves them.
- Outputs hold their last value until the next FINISH.
- `start` while `busy` is ignored; no queueing.

## Timing

- Let cycle 0 be the IDLE cycle with `start`=1. Let N = WIDTH/STEP.
- `busy`=1 in cycles 1..N+1. In cycle N+2, `done`=1 and `busy`=0.
- Latency from start to done is N+2 cycles: 34 for WIDTH=32/STEP=1, 10 for STEP=4.
- Back-to-back: `start` in the `done` cycle is accepted. That cycle is IDLE.
- Reset (synchronous) sets:
  - state IDLE
  - `busy`=0, `done`=0
  - `result_lo`=0, `result_hi`=0, `flags`=0
  - internal registers cleared
- Reset mid-operation aborts the operation; no `done` is produced.
- `reset` and `start` in the same cycle: reset wins and the start is dropped.
- No combinational path from inputs to outputs.

## Structure

- Package `mul_pkg` holds:
  - mode encodings MODE_MUL, MODE_MLA, MODE_UMULL, MODE_SMULL
  - state encoding
  - a STEP legality check used in an elaboration-time assertion
- Sub-module `mul_step` (combinational) is the natural split. It takes mcand, STEP multiplier bits and the accumulator, and returns the new accumulator.
- The FSM, counter and sign/MLA correction stay in `iter_multiplier`.
- The ARM control FSM adds a MULWAIT state keyed on `busy`/`done`. `IsLongMul` selects `mode[1]`.

## Test plan

- MUL, a=7, b=6, WIDTH=32, STEP=1 → `done` in cycle 34; lo=42, hi=0, flags N=0, Z=0; `busy` high in cycles 1..33.
- UMULL 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, N=1, Z=0.
- SMULL cases:
  - −2×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, N=1.
  - 0x80000000×0x80000000 → hi=0x40000000, lo=0.
  - 0×(−5) → Z=1.
- MLA a=0x10000, b=0x10000, acc=5 → lo=0x00000005 (wrap), hi=0, Z=0. Repeat with STEP=4: `done` in cycle 10, same result.
- `start` pulsed in cycle 5 during a busy MUL → ignored, first result intact. `start` in the `done` cycle → second operation completes N+2 cycles later.
- `reset` asserted in cycle 12 of a run → next cycle IDLE, all outputs 0, no `done` ever for that operation. `reset`+`start` together → remains IDLE.
